// File: rtl/sd_arb_pkg.sv
// Shared types and width helpers for the HPS virtual-disk channel arbiter.
package sd_arb_pkg;

  // Largest requester count the 3-bit grant index can address.
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } sd_state_t;

  // Top bit index of the sector-buffer data path.
  function automatic int buf_msb(input int wide);
    return (wide != 0) ? 15 : 7;
  endfunction

  // Sector-buffer data width in bits.
  function automatic int buf_width(input int wide);
    return buf_msb(wide) + 1;
  endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Combinational round-robin picker: first pending index after 'last', wrapping modulo NREQ.
module sd_arb_rr
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] pend,
  input  logic [2:0]      last,
  output logic            valid,
  output logic [2:0]      idx
);

  // Walk candidates last+1 .. last+NREQ; the first pending one wins.
  always_comb begin : pick
    logic [2:0] cand;
    logic       hit;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 3'((int'(last) + k) % NREQ);
      hit  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (cand == 3'(i)) hit = pend[i];
      end
      if (!valid && hit) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sd_arbiter.sv
// Shares one HPS virtual-disk block channel among NREQ requesters.
// Handshake: a requester holds req_rd/req_wr (level) until it sees its
// 1-cycle req_ack; req_done or req_err then closes the transaction. The
// arbiter holds sd_rd/sd_wr until sd_ack rises, and treats sd_ack falling
// as the end of the sector transfer.
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDE     = 0,
  parameter int TMO_BITS = 24
) (
  input  logic                                 clk_sys,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req_rd,
  input  logic [NREQ-1:0]                      req_wr,
  input  logic [32*NREQ-1:0]                   req_lba,
  output logic [NREQ-1:0]                      req_ack,
  output logic [NREQ-1:0]                      req_done,
  output logic [NREQ-1:0]                      req_err,
  output logic [NREQ-1:0]                      req_buff_wr,
  input  logic [buf_width(WIDE)*NREQ-1:0]      req_buff_din,
  output logic [31:0]                          sd_lba,
  output logic                                 sd_rd,
  output logic                                 sd_wr,
  input  logic                                 sd_ack,
  input  logic                                 sd_buff_wr,
  output logic [buf_msb(WIDE):0]               sd_buff_din,
  output logic                                 busy,
  output logic [2:0]                           grant,
  output logic [1:0]                           dbg_state
);

  localparam int BW = buf_width(WIDE);
  localparam logic [TMO_BITS-1:0] WDOG_ONE  = TMO_BITS'(1);
  localparam logic [TMO_BITS-1:0] WDOG_ONES = '1;

  sd_state_t           state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [31:0]         sd_lba_q, sd_lba_d;
  logic                sd_rd_q, sd_rd_d;
  logic                sd_wr_q, sd_wr_d;
  logic [NREQ-1:0]     req_ack_q, req_ack_d;
  logic [NREQ-1:0]     req_done_q, req_done_d;
  logic [NREQ-1:0]     req_err_q, req_err_d;
  logic [TMO_BITS-1:0] wdog_q, wdog_d;
  logic [TMO_BITS-1:0] wdog_inc;

  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] grant_oh;
  logic [31:0]     lba_arr [NREQ_MAX];
  logic [BW-1:0]   din_arr [NREQ_MAX];

  sd_arb_rr #(.NREQ(NREQ)) u_rr (
    .pend  (req_rd | req_wr),
    .last  (grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Unflatten per-requester buses and decode one-hot forms of pick and grant.
  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      lba_arr[i] = '0;
      din_arr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      lba_arr[i]  = req_lba[32*i +: 32];
      din_arr[i]  = req_buff_din[BW*i +: BW];
      pick_oh[i]  = (pick_idx == 3'(i));
      grant_oh[i] = (grant_q == 3'(i));
    end
  end

  // Next-state and registered-output logic of the channel FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    wdog_d     = wdog_q;
    req_ack_d  = '0;
    req_done_d = '0;
    req_err_d  = '0;
    wdog_inc   = wdog_q + WDOG_ONE;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          sd_lba_d = lba_arr[pick_idx];
          // Read wins when a requester raises both directions.
          sd_rd_d  = |(req_rd & pick_oh);
          sd_wr_d  = ~(|(req_rd & pick_oh));
          wdog_d   = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sd_ack) begin
          sd_rd_d   = 1'b0;
          sd_wr_d   = 1'b0;
          req_ack_d = grant_oh;
          state_d   = ST_XFER;
        end else if (!(|((req_rd | req_wr) & grant_oh))) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_IDLE;
        end else if (wdog_inc == WDOG_ONES) begin
          sd_rd_d   = 1'b0;
          sd_wr_d   = 1'b0;
          req_err_d = grant_oh;
          state_d   = ST_IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          req_done_d = grant_oh;
          state_d    = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'(NREQ - 1);
      sd_lba_q   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      req_ack_q  <= '0;
      req_done_q <= '0;
      req_err_q  <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      req_ack_q  <= req_ack_d;
      req_done_q <= req_done_d;
      req_err_q  <= req_err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Buffer strobe only reaches the granted requester during a transfer;
  // read data follows the last grant in every state.
  always_comb begin
    req_buff_wr = (state_q == ST_XFER && sd_buff_wr) ? grant_oh : '0;
    sd_buff_din = din_arr[grant_q];
  end

  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign req_ack   = req_ack_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_arbiter.sv
// Directed bench for sd_arbiter: NREQ=4, 8-bit buffer, 4-bit watchdog.
module tb_sd_arbiter;

  localparam int NREQ = 4;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_rd, req_wr;
  logic [32*NREQ-1:0]   req_lba;
  logic [NREQ-1:0]      req_ack, req_done, req_err, req_buff_wr;
  logic [8*NREQ-1:0]    req_buff_din;
  logic [31:0]          sd_lba;
  logic                 sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]           sd_buff_din;
  logic                 busy;
  logic [2:0]           grant;
  logic [1:0]           dbg_state;

  int total = 0;
  int bad   = 0;

  // Clock and DUT.
  always #5 clk_sys = ~clk_sys;

  sd_arbiter #(.NREQ(NREQ), .WIDE(0), .TMO_BITS(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .req_buff_wr  (req_buff_wr),
    .req_buff_din (req_buff_din),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant),
    .dbg_state    (dbg_state)
  );

  // Driver helpers: advance one cycle, sampling/driving 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full read service with requests left held; checks grant and pulses.
  task automatic serve(input int exp_g, input string tag);
    logic [3:0] oh;
    oh = 4'(1 << exp_g);
    tick();
    check({tag, "_grant"}, 32'(grant), 32'(exp_g));
    check({tag, "_rd"}, 32'(sd_rd), 32'd1);
    sd_ack = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(req_ack), 32'(oh));
    sd_ack = 1'b0;
    tick();
    check({tag, "_done"}, 32'(req_done), 32'(oh));
    tick();
  endtask

  int exp_order [5];
  int cnt_sel, cnt_other, n;

  initial begin
    reset        = 1'b1;
    req_rd       = '0;
    req_wr       = '0;
    req_lba      = '0;
    req_buff_din = '0;
    sd_ack       = 1'b0;
    sd_buff_wr   = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(sd_rd), 32'd0);
    check("rst_wr", 32'(sd_wr), 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_grant", 32'(grant), 32'd3);
    check("rst_pulses", 32'({req_ack, req_done, req_err}), 32'd0);
    reset = 1'b0;
    tick();

    // Single read on requester 2.
    req_rd[2] = 1'b1;
    req_lba[64 +: 32] = 32'h0000_1234;
    tick();
    check("rd1_rd", 32'(sd_rd), 32'd1);
    check("rd1_wr", 32'(sd_wr), 32'd0);
    check("rd1_lba", sd_lba, 32'h1234);
    check("rd1_grant", 32'(grant), 32'd2);
    req_lba[64 +: 32] = 32'hDEAD_BEEF;   // must be ignored while issuing
    tick(); tick(); tick();
    check("rd1_lba_hold", sd_lba, 32'h1234);
    check("rd1_no_ack_yet", 32'(req_ack), 32'd0);
    sd_ack = 1'b1;
    tick();
    check("rd1_ack", 32'(req_ack), 32'b0100);
    check("rd1_rd_drop", 32'(sd_rd), 32'd0);
    req_rd[2] = 1'b0;
    for (int c = 0; c < 14; c++) tick();
    check("rd1_ack_once", 32'(req_ack), 32'd0);
    check("rd1_busy_xfer", 32'(busy), 32'd1);
    sd_ack = 1'b0;
    tick();
    check("rd1_done", 32'(req_done), 32'b0100);
    check("rd1_busy_done", 32'(busy), 32'd1);
    tick();
    check("rd1_idle", 32'(busy), 32'd0);
    check("rd1_done_once", 32'(req_done), 32'd0);

    // Buffer routing with grant=1 (search starts at 3, wraps to 0, 1).
    req_wr[1] = 1'b1;
    req_lba[32 +: 32] = 32'hBEEF_0001;
    req_buff_din = {8'h3C, 8'h77, 8'hA5, 8'h5A};
    tick();
    check("buf_grant", 32'(grant), 32'd1);
    check("buf_wr", 32'(sd_wr), 32'd1);
    check("buf_rd", 32'(sd_rd), 32'd0);
    check("buf_lba", sd_lba, 32'hBEEF_0001);
    sd_ack = 1'b1;
    tick();
    check("buf_ack", 32'(req_ack), 32'b0010);
    req_wr[1] = 1'b0;
    check("buf_din", 32'(sd_buff_din), 32'hA5);
    cnt_sel = 0;
    cnt_other = 0;
    for (int p = 0; p < 512; p++) begin
      sd_buff_wr = 1'b1;
      #1;
      if (req_buff_wr[1]) cnt_sel++;
      if ((req_buff_wr & 4'b1101) != 4'b0000) cnt_other++;
      sd_buff_wr = 1'b0;
      tick();
    end
    check("buf_pulses_sel", 32'(cnt_sel), 32'd512);
    check("buf_pulses_other", 32'(cnt_other), 32'd0);
    sd_ack = 1'b0;
    tick();
    check("buf_done", 32'(req_done), 32'b0010);
    tick();
    check("buf_idle", 32'(busy), 32'd0);
    check("buf_din_kept", 32'(sd_buff_din), 32'hA5);

    // Stale ack and buffer strobe while idle.
    sd_ack = 1'b1;
    sd_buff_wr = 1'b1;
    #1;
    check("stale_bufwr", 32'(req_buff_wr), 32'd0);
    tick();
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_pulses", 32'({req_ack, req_done}), 32'd0);
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();

    // rd+wr together on requester 0: read direction wins.
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    tick();
    check("both_grant", 32'(grant), 32'd0);
    check("both_rd", 32'(sd_rd), 32'd1);
    check("both_wr", 32'(sd_wr), 32'd0);
    sd_ack = 1'b1;
    tick();
    req_rd[0] = 1'b0;
    req_wr[0] = 1'b0;
    sd_ack = 1'b0;
    tick();
    tick();

    // Cancel: requester 3 drops its write before sd_ack.
    req_wr[3] = 1'b1;
    tick();
    check("cancel_grant", 32'(grant), 32'd3);
    check("cancel_wr", 32'(sd_wr), 32'd1);
    req_wr[3] = 1'b0;
    tick();
    check("cancel_wr_drop", 32'(sd_wr), 32'd0);
    check("cancel_idle", 32'(busy), 32'd0);
    tick();
    check("cancel_no_pulses", 32'({req_ack, req_done, req_err}), 32'd0);

    // Watchdog: requesters 1 and 2 pending, no sd_ack for requester 1.
    req_rd[1] = 1'b1;
    req_rd[2] = 1'b1;
    tick();
    check("wd_grant", 32'(grant), 32'd1);
    n = 0;
    while (sd_rd && n < 40) begin
      tick();
      n++;
    end
    check("wd_cycles", 32'(n), 32'd15);
    check("wd_err", 32'(req_err), 32'b0010);
    check("wd_idle", 32'(busy), 32'd0);
    tick();
    check("wd_next_grant", 32'(grant), 32'd2);
    check("wd_next_rd", 32'(sd_rd), 32'd1);
    check("wd_err_once", 32'(req_err), 32'd0);
    sd_ack = 1'b1;
    tick();
    req_rd[2] = 1'b0;
    sd_ack = 1'b0;
    tick();
    tick();
    tick();
    check("wd_retry_grant", 32'(grant), 32'd1);
    req_rd[1] = 1'b0;
    tick();
    tick();

    // Reset in the middle of a transfer.
    req_rd[0] = 1'b1;
    tick();
    check("mrst_grant", 32'(grant), 32'd0);
    sd_ack = 1'b1;
    tick();
    check("mrst_ack", 32'(req_ack), 32'b0001);
    sd_buff_wr = 1'b1;
    reset = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_pulses", 32'({req_ack, req_done, req_err}), 32'd0);
    check("mrst_bufwr", 32'(req_buff_wr), 32'd0);
    check("mrst_grant_rst", 32'(grant), 32'd3);
    req_rd = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Round-robin with 0, 1, 3 held continuously from grant=3.
    exp_order = '{0, 1, 3, 0, 1};
    req_rd = 4'b1011;
    for (int s = 0; s < 5; s++) begin
      serve(exp_order[s], $sformatf("rr%0d", s));
    end
    req_rd = '0;
    tick();
    tick();
    check("rr_end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_arbiter.md
Name: sd_arbiter

Overview:
- Shares the single HPS virtual-disk block channel among NREQ independent requesters (e.g. floppy, HDD, DivMMC images in the ZX core).
- Drives sd_lba/sd_rd/sd_wr toward the hps_io block and tracks sd_ack.
- Routes sector-buffer traffic (sd_buff_wr, sd_buff_din) to and from the granted requester.
- Grants are round-robin with a watchdog on the issue phase.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- WIDE, 0: buffer width select; DW = WIDE ? 15 : 7.
- TMO_BITS, 24: watchdog counter width; timeout = 2^TMO_BITS-1 cycles.

Ports:
- clk_sys  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  NREQ  per-requester read request, level, held until req_ack.
- req_wr  in  NREQ  per-requester write request, level, held until req_ack.
- req_lba  in  32*NREQ  flattened LBA; slice i = [32*i +: 32].
- req_ack  out  NREQ  1-cycle pulse: HPS accepted the command of requester i.
- req_done  out  NREQ  1-cycle pulse: transfer of requester i finished.
- req_err  out  NREQ  1-cycle pulse: watchdog expired for requester i.
- req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester.
- req_buff_din  in  (DW+1)*NREQ  flattened per-requester buffer read data.
- sd_lba  out  32  to hps_io.
- sd_rd  out  1  to hps_io, single-disk bit.
- sd_wr  out  1  to hps_io, single-disk bit.
- sd_ack  in  1  from hps_io.
- sd_buff_wr  in  1  from hps_io.
- sd_buff_din  out  DW+1  to hps_io; mux of the granted requester's data.
- busy  out  1  state != IDLE.
- grant  out  3  index of the current/last granted requester.

Behaviour:
- Reset, async, immediate: state=IDLE; sd_rd=sd_wr=0; sd_lba=0; req_ack/req_done/req_err=0; grant=NREQ-1, so the first search starts at 0; watchdog=0.
- All control outputs are registered. req_buff_wr and sd_buff_din are combinational.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - pend[i] = req_rd[i] | req_wr[i].
  - Round-robin picks the first set pend at index grant+1, grant+2, ... modulo NREQ.
  - If any is found, the next cycle: grant=pick, sd_lba=req_lba[pick], dir latched (rd has priority if both rd and wr are set), sd_rd or sd_wr=1, watchdog cleared, state=ISSUE.
  - Latency from request to sd_rd/sd_wr is 1 cycle.
- ISSUE:
  - sd_ack=1: drop sd_rd/sd_wr, pulse req_ack[grant], state=XFER.
  - Requester drops both rd and wr before sd_ack (cancel): clear sd_rd/sd_wr, state=IDLE, no pulses.
  - Watchdog hits all-ones: clear sd_rd/sd_wr, pulse req_err[grant], state=IDLE. grant is kept, so the next search starts after it.
  - sd_lba is stable for all of ISSUE; changes on req_lba are ignored.
- XFER:
  - req_buff_wr[i] = sd_buff_wr & (i==grant) & (state==XFER).
  - sd_buff_din = req_buff_din slice[grant] in every state, so the last grant keeps driving.
  - sd_ack falling: pulse req_done[grant], state=DONE.
  - No watchdog in XFER; the HPS owns the transfer.
- DONE: one idle cycle, so a requester sees req_done before re-arbitration; then state=IDLE.
- Fairness: after servicing i, priority goes to i+1. A requester holding its request continuously is re-served only after the others.
- Simultaneous events: sd_ack rise and watchdog expiry in the same cycle → ack wins.
- sd_ack high while in IDLE (stale) is ignored; no buff_wr is routed.
- Reset mid-transfer: all outputs return to reset values at once. hps_io completes on its own.
- Indices ≥ NREQ are never granted.

Decomposition:
- Package sd_arb_pkg:
  - state enum (IDLE/ISSUE/XFER/DONE).
  - DW/width localparam functions.
  - NREQ_MAX=8.
- Sub-module sd_arb_rr: combinational round-robin picker.
  - Inputs: pend[NREQ], last[2:0].
  - Outputs: valid, idx[2:0].
  - Unit-testable in isolation.

Test Plan:
- Single read: req_rd[2]=1, lba[2]=0x1234; sd_ack high cycles 5..20 → sd_rd=1 cycle 1, sd_lba=0x1234, req_ack[2] pulse, req_done[2] pulse after ack falls, busy low 2 cycles later.
- Round-robin: req_rd[0], [1] and [3] held continuously, grant starts 3 → service order 0,1,3,0,1.
- Buffer routing, grant=1, WIDE=0: sd_buff_wr pulses ×512 → req_buff_wr[1] 512 pulses, other bits 0. Set req_buff_din[1]=0xA5 → sd_buff_din=0xA5.
- rd+wr both set on requester 0 → sd_rd=1, sd_wr=0.
- Watchdog, TMO_BITS=4, no sd_ack → req_err[grant] after 15 cycles, sd_rd=0, then the next pending requester is granted.
- Cancel and reset:
  - Drop req_wr during ISSUE → return to IDLE, no ack/done.
  - Assert reset during XFER → busy=0 and all pulse outputs 0 asynchronously, grant=NREQ-1.
